// File: rtl/memory_access_stage_if.sv
// memory_access_stage_if: req/ack data-memory port between the MEM stage and data memory.
interface memory_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/memory_access_stage.sv
// memory_access_stage: MIPS MEM stage; registers execute results, runs loads/stores over a
// req/ack port with lane steering and extension, and stalls upstream while an access is pending.
module memory_access_stage #(
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            bundle_in,
    input  logic [31:0]           pc_seq_in,
    input  logic [31:0]           alu_in,
    input  logic [31:0]           reg_read2_in,
    input  logic [4:0]            reg_write_dest_in,
    output logic                  stall_out,
    memory_access_stage_if.master dmem,
    output logic [3:0]            bundle_out,
    output logic [31:0]           pc_seq_out,
    output logic [31:0]           alu_out,
    output logic [31:0]           load_data_out,
    output logic [4:0]            reg_write_dest_out,
    output logic                  addr_err_out,
    output logic                  bus_err_out
);
    localparam logic [0:0]  IDLE = 1'b0;
    localparam logic [0:0]  WAIT = 1'b1;
    localparam logic [31:0] LAST = 32'(TIMEOUT - 1);

    logic [7:0]  bundle_q;
    logic [31:0] pc_q, alu_q, data_q, cnt, cur, ext;
    logic [4:0]  dest_q;
    logic [0:0]  state;
    logic        valid_q, mem_wr, mem_op, is_word, is_half, unsigned_ld;
    logic        misalign, req, ack, abort, stall, done, load_done;
    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign mem_wr      = bundle_q[1];
    assign mem_op      = bundle_q[0] | mem_wr;
    assign is_word     = bundle_q[5];
    assign is_half     = bundle_q[5:4] == 2'b01;
    assign unsigned_ld = bundle_q[6];
    assign off         = alu_q[1:0];
    assign misalign    = mem_op & (is_word ? |off : is_half & off[0]);
    assign req         = state == WAIT | (mem_op & ~misalign);
    assign ack         = req & dmem.dmem_ack;
    // cur counts request cycles already spent, so abort lands on the TIMEOUT-th req cycle
    assign cur         = state == WAIT ? cnt : '0;
    assign abort       = req & ~dmem.dmem_ack & (TIMEOUT != 0) & cur == LAST;
    assign stall       = req & ~ack & ~abort;
    assign done        = valid_q & ~stall;
    assign load_done   = ack & bundle_q[0] & ~mem_wr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bundle_q <= '0;
            pc_q     <= '0;
            alu_q    <= '0;
            data_q   <= '0;
            dest_q   <= '0;
            valid_q  <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
        end else begin
            if (!stall) begin
                bundle_q <= bundle_in;
                pc_q     <= pc_seq_in;
                alu_q    <= alu_in;
                data_q   <= reg_read2_in;
                dest_q   <= reg_write_dest_in;
                valid_q  <= 1'b1;
            end
            state <= stall ? WAIT : IDLE;
            cnt   <= stall ? cur + 32'd1 : '0;
        end
    end

    assign ld_byte = dmem.dmem_rdata[{off, 3'b000} +: 8];
    assign ld_half = off[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    assign ext     = is_word ? dmem.dmem_rdata
                   : is_half ? {{16{~unsigned_ld & ld_half[15]}}, ld_half}
                   : {{24{~unsigned_ld & ld_byte[7]}}, ld_byte};

    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = req & mem_wr;
    assign dmem.dmem_addr  = {alu_q[31:2], 2'b00};
    assign dmem.dmem_be    = ~req ? 4'b0000 : is_word ? 4'b1111
                           : is_half ? (off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << off;
    assign dmem.dmem_wdata = is_word ? data_q : is_half ? {2{data_q[15:0]}} : {4{data_q[7:0]}};

    assign stall_out          = stall;
    assign bundle_out         = {bundle_q[7] & done, bundle_q[3] & done,
                                 bundle_q[2] & done & ~misalign & ~abort, done};
    assign pc_seq_out         = pc_q;
    assign alu_out            = alu_q;
    assign reg_write_dest_out = dest_q;
    assign load_data_out      = load_done ? ext : '0;
    assign addr_err_out       = valid_q & misalign;
    assign bus_err_out        = abort;
endmodule
